// File: rtl/letter_uart_pkg.sv
// Shared types and line levels for the letter UART transmitter.
package letter_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int   FRAME_BITS  = 10;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/letter_fifo.sv
// Synchronous letter buffer between the upstream handshake and the serialiser.
module letter_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Pointers are exactly AW bits wide, so wrap is free for power-of-two depths.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/letter_uart_tx.sv
// Buffers 8-bit letters and sends each as a 10-bit UART frame (start, 8 data LSB-first, stop).
module letter_uart_tx
  import letter_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(FRAME_BITS - 3);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q;
  logic                done_q, done_d;
  logic                tick;
  logic                pop;
  logic                fifo_full, fifo_empty;
  logic [DATA_W-1:0]   pop_data;

  assign in_ready = !fifo_full;

  letter_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (DATA_W)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (in_valid && in_ready),
    .push_data_i(in_data),
    .pop_i      (pop),
    .pop_data_o (pop_data),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = pop_data;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          done_d = 1'b1;
          // Chain straight into the next start bit so frames stay contiguous.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = pop_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are registered off the current state, so they trail it by one cycle.
  always_comb begin
    case (state_q)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_q[0];
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != IDLE);
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/letter_uart_tx.md
Name: letter_uart_tx

Overview:
- Downstream consumer of the periodic letter generator: accepts 8-bit letter codes over a valid/ready handshake.
- Buffers the letters in a small FIFO and serialises each one as a UART-style frame: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- The serial line drives the board TX pin or a bench monitor, so the stored text can be observed as a bit stream.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥1.
- FIFO_DEPTH, 4, letter buffer entries; power of two, ≥2.
- DATA_W, 8, letter width; fixed at 8 for frame format.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a letter.
- in_data  in  8  letter code.
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a CLK edge.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high while a frame is on the line (any state except IDLE).
- frame_done  out  1  one-cycle pulse on the last cycle of each stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  letters currently buffered.

Behaviour:
- Reset values (RST high, asynchronous):
  - tx=1, busy=0, frame_done=0, fifo_count=0, in_ready=1.
  - FSM=IDLE, baud counter=0, bit index=0.
- in_ready is a combinational decode of the registered count: in_ready = (fifo_count < FIFO_DEPTH).
  - When full, a same-cycle pop does not enable a push; the upstream letter stays held until the next cycle.
  - in_data is sampled only on a transfer; in_valid while in_ready=0 has no effect.
- FIFO:
  - Push and pop in the same cycle when neither full nor empty leaves the count unchanged and the data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Baud counter runs 0..CLKS_PER_BIT-1. A bit boundary ("tick") is the cycle with counter = CLKS_PER_BIT-1. With CLKS_PER_BIT=1, every cycle is a tick.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0, pop the head into the shift register, clear the baud counter and go to START. tx=0 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles. At tick, go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. At each tick, shift right and increment the index. At tick with index=7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At tick, assert frame_done.
    - If the FIFO is non-empty in that same cycle, pop and go directly to START; there is no idle gap between frames.
    - Otherwise go to IDLE.
- Latency: letter pushed at edge t into an empty FIFO while IDLE → fifo_count=1 after t → pop at edge t+1 → tx falls after edge t+2.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- busy=1 in START/DATA/STOP, including the stop cycle that chains directly into the next START.
- Reset asserted mid-frame immediately forces tx=1 and clears the FIFO. The partial frame is abandoned and not resumed.
- Width rules: baud counter width $clog2(CLKS_PER_BIT) (minimum 1 bit); bit index is 3 bits; fifo_count never exceeds FIFO_DEPTH.

Decomposition:
- Package letter_uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP};
  - constants FRAME_BITS=10, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
- Sub-module letter_fifo (synchronous FIFO, push/pop/count/full/empty, async active-high reset). The serialiser FSM stays in the top module.

Test Plan:
- CLKS_PER_BIT=4, push 'H' (0x48) once → tx: 0 for 4 cycles, then data bits 0,0,0,1,0,0,1,0 for 4 cycles each, then 1 for 4 cycles. frame_done pulses at cycle 40 of the frame. busy falls after it. tx falls 2 edges after the push.
- Push "Hello World!" (12 bytes) with in_valid held → 12 contiguous frames, 480 cycles with no idle gap, 12 frame_done pulses.
  - in_ready low whenever fifo_count=4.
  - Decoded bytes 0x48 0x65 0x6C 0x6C 0x6F 0x20 0x57 0x6F 0x72 0x6C 0x64 0x21.
- Hold in_valid with 5 letters while the FSM is stalled in a long frame (CLKS_PER_BIT=16) → 4 accepted, 5th held (in_ready=0) until the first pop. No letter is lost or duplicated; output order matches input order.
- Assert RST for 1 cycle during DATA bit 3 of 'e' → tx=1 asynchronously, fifo_count=0, busy=0. After release, a pushed 'o' (0x6F) produces a clean full frame.
- CLKS_PER_BIT=1, push 0x00 then 0xFF → 20 consecutive cycles: 0, 0×8, 1, 0, 1×8, 1.
- Push while IDLE with a simultaneous pop on a non-empty FIFO (count=2) → count stays 2; data order intact.
